bmlp_layer_ctrl: RTL and testbench
==================================

# bmlp_layer_ctrl

Sequencer for one binary-MLP layer pass. On `start` it walks the 13-bit weight-memory address space linearly, one weight word per cycle, and generates the input-word index for each access. It also drives the accumulator control strobes (clear/enable/last) and the per-neuron output write, all aligned to a configurable weight-memory read latency. It sits between the top-level network FSM and the weight memory/XNOR-popcount datapath, and replaces free-running ripple counting with a start/done handshake.

## Interface
- `ADDR_W`, 13, weight-memory address width; max layer size is 2^ADDR_W words.
- `IDX_W`, 8, width of input-word and neuron counts/indices.
- `RD_LAT`, 1, weight-memory read latency in cycles (≥1).
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  request a layer pass; sampled only in IDLE.
- `cfg_in_words`  in  IDX_W  weight words per neuron; latched at accepted start.
- `cfg_neurons`  in  IDX_W  neurons in the layer; latched at accepted start.
- `hold`  in  1  stall address issue; counters freeze.
- `busy`  out  1  high whenever state ≠ IDLE.
- `done`  out  1  one-cycle pulse at end of pass.
- `err`  out  1  one-cycle pulse when start is rejected.
- `wmem_re`  out  1  weight read strobe.
- `wmem_addr`  out  ADDR_W  weight read address.
- `in_addr`  out  IDX_W  input-word index for the current issue.
- `acc_clr`  out  1  first word of a neuron at accumulator stage.
- `acc_en`  out  1  valid weight word at accumulator stage.
- `acc_last`  out  1  last word of a neuron at accumulator stage.
- `out_we`  out  1  write finished neuron result.
- `out_addr`  out  IDX_W  neuron index for `out_we`.

## Operation
- States: IDLE, RUN, DRAIN, DONE.
- IDLE: a start is accepted when `start`=1, both cfg values are nonzero, and `cfg_in_words*cfg_neurons` ≤ 2^ADDR_W. The product is computed at full 2·IDX_W width.
  - On acceptance: latch cfg, clear counters, go to RUN.
  - Otherwise: pulse `err` and stay in IDLE.
- RUN: each cycle with `hold`=0:
  - Assert `wmem_re` and issue `wmem_addr`/`in_addr`.
  - `wmem_addr` then increments. `in_addr` increments and wraps to 0 after `cfg_in_words`-1; at the wrap the internal neuron index increments.
  - After the last word (address N-1, with N = in_words·neurons) is issued, go to DRAIN.
- With `hold`=1 in RUN: `wmem_re`=0 and all issue counters hold. Words already issued continue down the pipeline.
- Pipeline: (re, first, last, neuron idx) is delayed RD_LAT cycles to produce `acc_en`, `acc_clr`, `acc_last`. `out_we`/`out_addr` are `acc_last`/neuron idx delayed one more cycle. `acc_clr` and `acc_last` are only ever high together with `acc_en`.
- `cfg_in_words`=1: `acc_clr` and `acc_last` are both high on every word.
- DRAIN: `hold` is ignored. Wait until the final `out_we` has been emitted, then go to DONE.
- DONE: `done`=1 for one cycle, then IDLE.
- `start` while busy is ignored, with no `err`. Cfg inputs are don't-care while busy.
- Reset (any state, including mid-RUN): at the next edge, state=IDLE, all counters and pipeline stages are cleared, and no pending strobe may appear afterward.
- Reset values: every output = 0.

## Timing
- Start sampled at edge c0-1; first issue (`wmem_re`=1, addr 0) in cycle c0; `busy` is high from c0.
- With no hold, word k is issued at c0+k and its `acc_en` occurs at c0+k+RD_LAT.
- `out_we` for neuron j occurs at c0+(j+1)·in_words−1+RD_LAT+1.
- `done` occurs the cycle after the final `out_we`; `busy` is low the following cycle.
- Each hold cycle in RUN shifts all later events by one cycle.
- Back-to-back: `start` may be sampled in the first IDLE cycle after DONE.

## Test plan
- in_words=4, neurons=3, RD_LAT=1, no hold: `wmem_addr` 0..11 at c0..c0+11; `in_addr` 0,1,2,3 repeating; `acc_clr` at c0+1/5/9; `out_we` at c0+5/9/13 with `out_addr` 0/1/2; `done` at c0+14.
- Same config, `hold` high for cycles c0+2..c0+4: addr 2 is issued at c0+5; every later event +3; `done` at c0+17.
- in_words=128, neurons=64 (N=8192): last addr 8191, accepted. in_words=129, neurons=64: `err` pulse, `busy` stays 0. in_words=0: `err`.
- in_words=1, neurons=5, RD_LAT=2: `acc_clr`=`acc_last`=`acc_en` on 5 consecutive cycles starting c0+2; `out_we` on 5 consecutive cycles starting c0+3.
- `rst` asserted at c0+6 of a 4×3 pass: all outputs are 0 from the next cycle, with no `out_we`/`done` after. A new start then runs from addr 0.
- `start` pulsed during RUN: ignored, no `err`, pass unchanged.

Source files
------------

// File: rtl/bmlp_layer_ctrl_if.sv
// ---------------------------------------------------------------------------
// bmlp_layer_ctrl_if
//   Bundles the control, configuration and datapath-strobe signals of one
//   binary-MLP layer sequencer.
//
//   master : network FSM side. Drives start/cfg/hold and observes status,
//            weight-memory and accumulator strobes.
//   slave  : the sequencer itself (bmlp_layer_ctrl).
//
//   start/done handshake: a pass is requested by holding start high for a
//   cycle while busy is low. A request with a legal configuration raises busy
//   on the following cycle. A request with an illegal configuration returns a
//   single-cycle err pulse instead. Each accepted pass ends with exactly one
//   single-cycle done pulse, and busy drops on the cycle after done. start is
//   ignored while busy is high.
// ---------------------------------------------------------------------------
interface bmlp_layer_ctrl_if #(
   parameter int ADDR_W = 13,
   parameter int IDX_W  = 8
);
   logic              start;
   logic [IDX_W-1:0]  cfg_in_words;
   logic [IDX_W-1:0]  cfg_neurons;
   logic              hold;

   logic              busy;
   logic              done;
   logic              err;
   logic              wmem_re;
   logic [ADDR_W-1:0] wmem_addr;
   logic [IDX_W-1:0]  in_addr;
   logic              acc_clr;
   logic              acc_en;
   logic              acc_last;
   logic              out_we;
   logic [IDX_W-1:0]  out_addr;
   logic [1:0]        dbg_state;

   modport master (
      output start, cfg_in_words, cfg_neurons, hold,
      input  busy, done, err, wmem_re, wmem_addr, in_addr,
             acc_clr, acc_en, acc_last, out_we, out_addr, dbg_state
   );

   modport slave (
      input  start, cfg_in_words, cfg_neurons, hold,
      output busy, done, err, wmem_re, wmem_addr, in_addr,
             acc_clr, acc_en, acc_last, out_we, out_addr, dbg_state
   );
endinterface

// File: rtl/bmlp_layer_ctrl.sv
// ---------------------------------------------------------------------------
// bmlp_layer_ctrl
//   Sequencer for one binary-MLP layer pass. After an accepted start it walks
//   the weight memory linearly, issuing one word per cycle unless hold is
//   high. Alongside each weight address it generates the matching input-word
//   index. It delays the first/last/neuron tags by the memory read latency to
//   drive the accumulator strobes, then the per-neuron result write.
//
//   Ports
//     clk  : rising-edge clock
//     rst  : synchronous active-high reset
//     bus  : bmlp_layer_ctrl_if.slave
//            start, cfg_in_words, cfg_neurons, hold   (in)
//            busy, done, err                           (status out)
//            wmem_re, wmem_addr, in_addr               (issue stage out)
//            acc_clr, acc_en, acc_last                 (accumulator stage out)
//            out_we, out_addr                          (result write out)
//            dbg_state                                 (FSM state, debug)
// ---------------------------------------------------------------------------
module bmlp_layer_ctrl #(
   parameter int ADDR_W = 13,
   parameter int IDX_W  = 8,
   parameter int RD_LAT = 1
) (
   input  logic              clk,
   input  logic              rst,
   bmlp_layer_ctrl_if.slave  bus
);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_RUN   = 2'd1;
   localparam logic [1:0] S_DRAIN = 2'd2;
   localparam logic [1:0] S_DONE  = 2'd3;

   localparam logic [IDX_W-1:0]  IDX_ONE  = {{(IDX_W-1){1'b0}}, 1'b1};
   localparam logic [ADDR_W-1:0] ADDR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};
   // Largest legal layer: 2^ADDR_W words, held one bit wider than the product.
   localparam logic [2*IDX_W:0]  MAX_WORDS = {{(2*IDX_W){1'b0}}, 1'b1} << ADDR_W;

   logic [1:0]        state_q, state_d;
   logic [IDX_W-1:0]  in_last_q;
   logic [IDX_W-1:0]  nrn_last_q;
   logic [ADDR_W-1:0] wa_q;
   logic [IDX_W-1:0]  in_q;
   logic [IDX_W-1:0]  nrn_q;

   // Read-latency delay line. Index 0 is loaded at the issue edge, and
   // index RD_LAT-1 is the accumulator stage.
   logic [RD_LAT-1:0] p_re_q;
   logic [RD_LAT-1:0] p_first_q;
   logic [RD_LAT-1:0] p_last_q;
   logic [IDX_W-1:0]  p_nidx_q [RD_LAT];

   logic              out_we_q;
   logic [IDX_W-1:0]  out_addr_q;
   logic              err_q;

   logic [2*IDX_W-1:0] prod;
   logic               cfg_ok;
   logic               accept;
   logic               issue;
   logic               word_first;
   logic               word_last;
   logic               final_word;
   logic               acc_en;
   logic               acc_last;
   logic               final_out;

   // The product is formed at full 2*IDX_W width, so it can never overflow.
   assign prod   = {{IDX_W{1'b0}}, bus.cfg_in_words} * {{IDX_W{1'b0}}, bus.cfg_neurons};
   assign cfg_ok = (bus.cfg_in_words != '0) && (bus.cfg_neurons != '0) &&
                   ({1'b0, prod} <= MAX_WORDS);
   assign accept = (state_q == S_IDLE) && bus.start && cfg_ok;

   assign issue      = (state_q == S_RUN) && !bus.hold;
   assign word_first = (in_q == '0);
   assign word_last  = (in_q == in_last_q);
   assign final_word = word_last && (nrn_q == nrn_last_q);

   assign acc_en   = p_re_q[RD_LAT-1];
   assign acc_last = p_last_q[RD_LAT-1];

   // Only the final neuron's write ends the drain. Earlier neurons can still
   // be writing back while the FSM is already in DRAIN.
   assign final_out = out_we_q && (out_addr_q == nrn_last_q);

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:  if (accept)              state_d = S_RUN;
         S_RUN:   if (issue && final_word) state_d = S_DRAIN;
         S_DRAIN: if (final_out)           state_d = S_DONE;
         S_DONE:                           state_d = S_IDLE;
         default:                          state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= S_IDLE;
         in_last_q  <= '0;
         nrn_last_q <= '0;
         wa_q       <= '0;
         in_q       <= '0;
         nrn_q      <= '0;
         err_q      <= 1'b0;
      end else begin
         state_q <= state_d;
         err_q   <= (state_q == S_IDLE) && bus.start && !cfg_ok;
         if (accept) begin
            in_last_q  <= bus.cfg_in_words - IDX_ONE;
            nrn_last_q <= bus.cfg_neurons - IDX_ONE;
            wa_q       <= '0;
            in_q       <= '0;
            nrn_q      <= '0;
         end else if (issue) begin
            if (final_word) begin
               // Park the counters at zero so the address bus idles at 0
               // between passes. This includes the 2^ADDR_W case, where
               // wa_q would otherwise wrap.
               wa_q  <= '0;
               in_q  <= '0;
               nrn_q <= '0;
            end else begin
               wa_q <= wa_q + ADDR_ONE;
               if (word_last) begin
                  in_q  <= '0;
                  nrn_q <= nrn_q + IDX_ONE;
               end else begin
                  in_q <= in_q + IDX_ONE;
               end
            end
         end
      end
   end

   // The first and last tags are gated with issue at entry. That way
   // acc_clr and acc_last can never appear without acc_en.
   always_ff @(posedge clk) begin
      if (rst) begin
         p_re_q    <= '0;
         p_first_q <= '0;
         p_last_q  <= '0;
         for (int i = 0; i < RD_LAT; i++) p_nidx_q[i] <= '0;
         out_we_q   <= 1'b0;
         out_addr_q <= '0;
      end else begin
         for (int i = RD_LAT - 1; i > 0; i--) begin
            p_re_q[i]    <= p_re_q[i-1];
            p_first_q[i] <= p_first_q[i-1];
            p_last_q[i]  <= p_last_q[i-1];
            p_nidx_q[i]  <= p_nidx_q[i-1];
         end
         p_re_q[0]    <= issue;
         p_first_q[0] <= issue && word_first;
         p_last_q[0]  <= issue && word_last;
         p_nidx_q[0]  <= issue ? nrn_q : '0;
         out_we_q     <= acc_en && acc_last;
         out_addr_q   <= (acc_en && acc_last) ? p_nidx_q[RD_LAT-1] : '0;
      end
   end

   assign bus.busy      = (state_q != S_IDLE);
   assign bus.done      = (state_q == S_DONE);
   assign bus.err       = err_q;
   assign bus.wmem_re   = issue;
   assign bus.wmem_addr = wa_q;
   assign bus.in_addr   = in_q;
   assign bus.acc_en    = acc_en;
   assign bus.acc_clr   = p_first_q[RD_LAT-1];
   assign bus.acc_last  = acc_last;
   assign bus.out_we    = out_we_q;
   assign bus.out_addr  = out_addr_q;
   assign bus.dbg_state = state_q;

endmodule

// File: tb/tb_bmlp_layer_ctrl.sv
// ---------------------------------------------------------------------------
// tb_bmlp_layer_ctrl
//   Two sequencers, one with read latency 1 and one with latency 2, receive
//   identical stimulus. For every pass, a reference model derives the event
//   timeline from the timing rules: issue cycles come from walking word
//   indices past the hold pattern, and the accumulator, write and done events
//   are placed at fixed offsets from those cycles. Each event is tagged with
//   its cycle and sequencer, then pushed into one sorted expected queue. A
//   negedge monitor turns the outputs it sees into the same event encoding
//   and pops or compares them against that queue.
//   Event word: [63:32] cycle, [31] dut, [30:28] type, [27:0] payload.
//     type 0 err, 1 issue {addr,in_addr}, 2 acc {clr,last}, 3 out_we idx,
//     4 done
// ---------------------------------------------------------------------------
module tb_bmlp_layer_ctrl;

   logic       clk = 1'b0;
   logic       rst;
   logic       start;
   logic [7:0] cfg_iw;
   logic [7:0] cfg_nn;
   logic       hold;

   int cyc = 0;
   int vectors = 0;
   int miscompares = 0;
   bit mon_en = 1'b0;
   int zero_chk_cyc = -1;
   int busy_lo [2];
   int busy_hi [2];

   logic [63:0] exp_q[$];
   bit          hold_a[];

   logic        o_busy [2];
   logic        o_done [2];
   logic        o_err  [2];
   logic        o_re   [2];
   logic [12:0] o_addr [2];
   logic [7:0]  o_in   [2];
   logic        o_clr  [2];
   logic        o_en   [2];
   logic        o_last [2];
   logic        o_we   [2];
   logic [7:0]  o_oaddr[2];
   logic [1:0]  o_state[2];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   for (genvar g = 0; g < 2; g++) begin : g_dut
      bmlp_layer_ctrl_if #(.ADDR_W(13), .IDX_W(8)) bus ();
      assign bus.start        = start;
      assign bus.cfg_in_words = cfg_iw;
      assign bus.cfg_neurons  = cfg_nn;
      assign bus.hold         = hold;
      bmlp_layer_ctrl #(.ADDR_W(13), .IDX_W(8), .RD_LAT(g + 1)) u_dut (
         .clk (clk),
         .rst (rst),
         .bus (bus)
      );
      assign o_busy[g]  = bus.busy;
      assign o_done[g]  = bus.done;
      assign o_err[g]   = bus.err;
      assign o_re[g]    = bus.wmem_re;
      assign o_addr[g]  = bus.wmem_addr;
      assign o_in[g]    = bus.in_addr;
      assign o_clr[g]   = bus.acc_clr;
      assign o_en[g]    = bus.acc_en;
      assign o_last[g]  = bus.acc_last;
      assign o_we[g]    = bus.out_we;
      assign o_oaddr[g] = bus.out_addr;
      assign o_state[g] = bus.dbg_state;
   end

   function automatic logic [63:0] ev(input int c, input int d, input int ty, input int p);
      logic [31:0] cc;
      logic [2:0]  tt;
      logic [27:0] pp;
      logic        dd;
      cc = c;
      dd = d[0];
      tt = ty[2:0];
      pp = p[27:0];
      return {cc, dd, tt, pp};
   endfunction

   // ---------------- monitor / scoreboard ----------------
   always @(negedge clk) begin
      logic [63:0] obs[$];
      logic [63:0] head;
      logic        exp_b;
      if (mon_en) begin
         for (int d = 0; d < 2; d++) begin
            obs.delete();
            if (o_err[d])  obs.push_back(ev(cyc, d, 0, 0));
            if (o_re[d])   obs.push_back(ev(cyc, d, 1, int'(o_addr[d]) * 256 + int'(o_in[d])));
            if (o_en[d])   obs.push_back(ev(cyc, d, 2, (o_clr[d] ? 2 : 0) + (o_last[d] ? 1 : 0)));
            if (o_we[d])   obs.push_back(ev(cyc, d, 3, int'(o_oaddr[d])));
            if (o_done[d]) obs.push_back(ev(cyc, d, 4, 0));
            foreach (obs[i]) begin
               vectors++;
               head = (exp_q.size() > 0) ? exp_q[0] : '1;
               if (exp_q.size() > 0 && exp_q[0] == obs[i]) begin
                  void'(exp_q.pop_front());
               end else begin
                  miscompares++;
                  $display("FAIL event dut%0d cyc %0d state %0d: got %h, expected %h",
                           d, cyc, o_state[d], obs[i], head);
               end
            end
            // Anything still due at or before this cycle for this DUT never showed up.
            while (exp_q.size() > 0 && int'(exp_q[0][63:32]) <= cyc &&
                   int'(exp_q[0][31]) <= d) begin
               vectors++;
               miscompares++;
               $display("FAIL missing dut%0d cyc %0d: got none, expected %h", d, cyc, exp_q[0]);
               void'(exp_q.pop_front());
            end
            vectors++;
            exp_b = (cyc >= busy_lo[d]) && (cyc <= busy_hi[d]);
            if (o_busy[d] !== exp_b) begin
               miscompares++;
               $display("FAIL busy dut%0d cyc %0d: got %b, expected %b", d, cyc, o_busy[d], exp_b);
            end
            vectors++;
            if ((o_clr[d] || o_last[d]) && !o_en[d]) begin
               miscompares++;
               $display("FAIL strobe dut%0d cyc %0d: got clr %b last %b en %b, expected en high",
                        d, cyc, o_clr[d], o_last[d], o_en[d]);
            end
            if (cyc == zero_chk_cyc) begin
               vectors++;
               if ({o_busy[d], o_done[d], o_err[d], o_re[d], o_addr[d], o_in[d], o_clr[d],
                    o_en[d], o_last[d], o_we[d], o_oaddr[d]} !== '0) begin
                  miscompares++;
                  $display("FAIL reset_outs dut%0d cyc %0d: got re %b addr %0d in %0d en %b we %b busy %b, expected all 0",
                           d, cyc, o_re[d], o_addr[d], o_in[d], o_en[d], o_we[d], o_busy[d]);
               end
            end
         end
      end
   end

   // ---------------- reference model ----------------
   // Word k is issued on the k-th cycle from c0 that is not a hold cycle.
   // Its accumulator strobe follows L cycles after issue. A neuron's
   // result write follows its last word's accumulator strobe by one
   // cycle, and done follows the final write.
   task automatic model_pass(input int d, input int L, input int c0, input int iw,
                             input int nn, output int dcyc);
      int off = 0;
      int k = 0;
      int tk;
      int lo = 0;
      while (k < iw * nn) begin
         if (off < hold_a.size() && hold_a[off]) begin
            off++;
         end else begin
            tk = c0 + off;
            exp_q.push_back(ev(tk, d, 1, k * 256 + (k % iw)));
            exp_q.push_back(ev(tk + L, d, 2, ((k % iw == 0) ? 2 : 0) + ((k % iw == iw - 1) ? 1 : 0)));
            if (k % iw == iw - 1) begin
               lo = tk + L + 1;
               exp_q.push_back(ev(lo, d, 3, k / iw));
            end
            k++;
            off++;
         end
      end
      dcyc = lo + 1;
      exp_q.push_back(ev(dcyc, d, 4, 0));
      busy_lo[d] = c0;
      busy_hi[d] = dcyc;
   endtask

   task automatic flush_after(input int rc);
      while (exp_q.size() > 0 && int'(exp_q[$][63:32]) > rc) void'(exp_q.pop_back());
      for (int d = 0; d < 2; d++) if (busy_hi[d] > rc) busy_hi[d] = rc;
   endtask

   // ---------------- driver ----------------
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // hmode: 0 no hold, 1 hold at c0+2..c0+4, 2 random hold (~25%).
   // rst_off >= 0 asserts reset during cycle c0+rst_off. pulse re-asserts
   // start with junk cfg at c0+3.
   task automatic do_pass(input int iw, input int nn, input int hmode, input int rst_off,
                          input bit pulse);
      int n;
      int c0;
      int d0;
      int d1;
      int off;
      n = iw * nn;
      start  = 1'b1;
      cfg_iw = iw[7:0];
      cfg_nn = nn[7:0];
      if (iw == 0 || nn == 0 || n > 8192) begin
         exp_q.push_back(ev(cyc + 1, 0, 0, 0));
         exp_q.push_back(ev(cyc + 1, 1, 0, 0));
         exp_q.sort();
         step();
         start  = 1'b0;
         cfg_iw = 8'($urandom_range(0, 255));
         repeat (2) step();
         return;
      end
      c0 = cyc + 1;
      hold_a = new[2 * n + 8];
      foreach (hold_a[i])
         hold_a[i] = (hmode == 1) ? (i >= 2 && i <= 4) :
                     (hmode == 2) ? ($urandom_range(0, 99) < 25) : 1'b0;
      model_pass(0, 1, c0, iw, nn, d0);
      model_pass(1, 2, c0, iw, nn, d1);
      exp_q.sort();
      step();
      start = 1'b0;
      off = 0;
      while (cyc <= d1) begin
         hold = (off < hold_a.size()) ? hold_a[off] : 1'b0;
         if (pulse && off == 3) begin
            start  = 1'b1;
            cfg_iw = 8'($urandom_range(0, 255));
            cfg_nn = 8'($urandom_range(0, 255));
         end else begin
            start = 1'b0;
         end
         if (off == rst_off) begin
            rst = 1'b1;
            flush_after(cyc);
            step();
            zero_chk_cyc = cyc;
            rst = 1'b0;
            break;
         end
         step();
         off++;
      end
      hold   = 1'b0;
      start  = 1'b0;
      hold_a = new[0];
   endtask

   // ---------------- test sequence ----------------
   initial begin
      rst    = 1'b1;
      start  = 1'b0;
      hold   = 1'b0;
      cfg_iw = '0;
      cfg_nn = '0;
      for (int d = 0; d < 2; d++) begin
         busy_lo[d] = 1;
         busy_hi[d] = 0;
      end
      repeat (2) step();
      mon_en = 1'b1;
      zero_chk_cyc = cyc;
      step();
      rst = 1'b0;
      step();

      do_pass(4, 3, 0, -1, 1'b0);     // basic 4x3
      do_pass(4, 3, 1, -1, 1'b0);     // hold c0+2..c0+4
      do_pass(1, 5, 0, -1, 1'b0);     // single-word neurons
      do_pass(4, 3, 0, -1, 1'b1);     // start while busy ignored
      do_pass(129, 64, 0, -1, 1'b0);  // N = 8256 rejected
      do_pass(0, 7, 0, -1, 1'b0);     // zero in_words rejected
      do_pass(9, 0, 0, -1, 1'b0);     // zero neurons rejected
      do_pass(4, 3, 0, 6, 1'b0);      // reset mid-RUN
      repeat (3) step();
      do_pass(4, 3, 0, -1, 1'b0);     // restarts from addr 0
      do_pass(128, 64, 0, -1, 1'b0);  // N = 8192, largest legal
      do_pass(1, 1, 0, -1, 1'b0);     // smallest pass
      for (int r = 0; r < 12; r++) begin
         do_pass($urandom_range(1, 20), $urandom_range(1, 12), 2, -1, 1'($urandom_range(0, 1)));
         if (r % 4 == 3)
            do_pass($urandom_range(65, 255), $urandom_range(128, 255), 0, -1, 1'b0);
      end
      repeat (4) step();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
